// File: rtl/clk_gen_pkg.sv
// Shared definitions for the multi-channel clock-enable generator.
// Holds reset defaults, the channel-select width helper and the channel state record.
package clk_gen_pkg;

    localparam int unsigned CntWDef    = 24;
    localparam int unsigned DefHalfDef = 262144;

    // Channel select is never narrower than one bit, even for a single channel.
    function automatic int unsigned ch_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef struct packed {
        logic [CntWDef-1:0] cnt;
        logic [CntWDef-1:0] half;
        logic [CntWDef-1:0] pend;
        logic               pend_valid;
        logic               sq;
    } chan_state_t;

endpackage

// File: rtl/clk_en_chan.sv
// One divider channel: square wave, rising-edge tick and a pending half-period
// that only takes effect at a terminal count so no runt half-cycle is produced.
module clk_en_chan
    import clk_gen_pkg::*;
#(
    parameter int unsigned CNT_W    = CntWDef,
    parameter int unsigned DEF_HALF = DefHalfDef
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             sync_i,
    input  logic             wr_i,
    input  logic [CNT_W-1:0] wr_half_i,
    output logic             sq_o,
    output logic             tick_o
);

    localparam logic [CNT_W-1:0] DefHalfW = CNT_W'(DEF_HALF);
    localparam logic [CNT_W-1:0] One      = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] half_q, half_d;
    logic [CNT_W-1:0] pend_q, pend_d;
    logic             pend_valid_q, pend_valid_d;
    logic             sq_q, sq_d;
    logic             tick_q, tick_d;
    logic             terminal;

    // Using >= also recovers from a counter that somehow sits at or past half.
    assign terminal = (cnt_q >= (half_q - One));

    always_comb begin
        cnt_d        = cnt_q;
        half_d       = half_q;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        sq_d         = sq_q;
        tick_d       = 1'b0;

        if (sync_i) begin
            cnt_d        = '0;
            sq_d         = 1'b0;
            pend_valid_d = 1'b0;
            if (wr_i) begin
                half_d = wr_half_i;
            end else if (pend_valid_q) begin
                half_d = pend_q;
            end
        end else begin
            if (en_i) begin
                if (terminal) begin
                    cnt_d  = '0;
                    sq_d   = ~sq_q;
                    tick_d = ~sq_q;
                    if (pend_valid_q) begin
                        half_d       = pend_q;
                        pend_valid_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + One;
                end
            end
            // A write landing on a terminal count stays pending for the next one.
            if (wr_i) begin
                pend_d       = wr_half_i;
                pend_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q        <= '0;
            half_q       <= DefHalfW;
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
            sq_q         <= 1'b0;
            tick_q       <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            half_q       <= half_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            sq_q         <= sq_d;
            tick_q       <= tick_d;
        end
    end

    assign sq_o   = sq_q;
    assign tick_o = tick_q;

endmodule

// File: rtl/clk_en_gen.sv
// Multi-channel clock-enable generator: decodes and validates config writes,
// then fans them out to NUM_CH independent divider channels.
module clk_en_gen
    import clk_gen_pkg::*;
#(
    parameter int unsigned CNT_W    = CntWDef,
    parameter int unsigned NUM_CH   = 2,
    parameter int unsigned DEF_HALF = DefHalfDef,
    localparam int unsigned CH_W    = ch_width(NUM_CH)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic              sync_i,
    input  logic              cfg_we_i,
    input  logic [CH_W-1:0]   cfg_ch_i,
    input  logic [CNT_W-1:0]  cfg_half_i,
    output logic [NUM_CH-1:0] sq_o,
    output logic [NUM_CH-1:0] tick_o,
    output logic              cfg_err_o
);

    logic              cfg_valid;
    logic [NUM_CH-1:0] wr;
    logic              cfg_err_q, cfg_err_d;

    assign cfg_valid = (cfg_half_i != '0) && (32'(cfg_ch_i) < NUM_CH);
    assign cfg_err_d = cfg_we_i && !cfg_valid;

    always_comb begin
        wr = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            wr[i] = cfg_we_i && cfg_valid && (32'(cfg_ch_i) == i);
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
        clk_en_chan #(
            .CNT_W    (CNT_W),
            .DEF_HALF (DEF_HALF)
        ) u_chan (
            .clk_i     (clk_i),
            .rst_i     (rst_i),
            .en_i      (en_i),
            .sync_i    (sync_i),
            .wr_i      (wr[g]),
            .wr_half_i (cfg_half_i),
            .sq_o      (sq_o[g]),
            .tick_o    (tick_o[g])
        );
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cfg_err_q <= 1'b0;
        end else begin
            cfg_err_q <= cfg_err_d;
        end
    end

    assign cfg_err_o = cfg_err_q;

endmodule

// File: tb/tb_clk_en_gen.sv
// Bench for clk_en_gen: directed scenarios followed by random traffic, all
// checked every cycle against a toggle-countdown reference model.
module tb_clk_en_gen;

    localparam int unsigned NCH = 3;
    localparam int unsigned CW  = 16;
    localparam int unsigned DEF = 37;

    logic           clk = 1'b0;
    logic           rst, en, sync, cfg_we;
    logic [1:0]     cfg_ch;
    logic [CW-1:0]  cfg_half;
    logic [NCH-1:0] sq, tick;
    logic           cfg_err;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: each channel counts down the edges left until its next toggle.
    int unsigned m_rem  [NCH];
    int unsigned m_half [NCH];
    int unsigned m_pend [NCH];
    bit          m_pv   [NCH];
    bit          m_lvl  [NCH];
    bit          m_tk   [NCH];
    bit          m_err;

    always #5 clk = ~clk;

    clk_en_gen #(
        .CNT_W    (CW),
        .NUM_CH   (NCH),
        .DEF_HALF (DEF)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .en_i       (en),
        .sync_i     (sync),
        .cfg_we_i   (cfg_we),
        .cfg_ch_i   (cfg_ch),
        .cfg_half_i (cfg_half),
        .sq_o       (sq),
        .tick_o     (tick),
        .cfg_err_o  (cfg_err)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge(input bit r, input bit e, input bit s, input bit we,
                              input int unsigned ch, input int unsigned h);
        bit valid;
        valid = (h != 0) && (ch < NCH);
        if (r) begin
            for (int i = 0; i < NCH; i++) begin
                m_lvl[i] = 0; m_tk[i] = 0; m_half[i] = DEF; m_rem[i] = DEF; m_pv[i] = 0;
            end
            m_err = 0;
            return;
        end
        m_err = we && !valid;
        for (int i = 0; i < NCH; i++) begin
            bit hit;
            hit = we && valid && (ch == i);
            m_tk[i] = 0;
            if (s) begin
                m_lvl[i] = 0;
                if (hit) m_half[i] = h;
                else if (m_pv[i]) m_half[i] = m_pend[i];
                m_pv[i]  = 0;
                m_rem[i] = m_half[i];
            end else begin
                if (e) begin
                    m_rem[i]--;
                    if (m_rem[i] == 0) begin
                        m_lvl[i] = !m_lvl[i];
                        m_tk[i]  = m_lvl[i];
                        if (m_pv[i]) begin
                            m_half[i] = m_pend[i];
                            m_pv[i]   = 0;
                        end
                        m_rem[i] = m_half[i];
                    end
                end
                if (hit) begin
                    m_pend[i] = h;
                    m_pv[i]   = 1;
                end
            end
        end
    endtask

    task automatic cyc(input bit r, input bit e, input bit s, input bit we,
                       input int unsigned ch, input int unsigned h);
        logic [NCH-1:0] exp_sq, exp_tk;
        rst = r; en = e; sync = s; cfg_we = we;
        cfg_ch = 2'(ch); cfg_half = CW'(h);
        @(posedge clk);
        model_edge(r, e, s, we, ch, h);
        #1;
        for (int i = 0; i < NCH; i++) begin
            exp_sq[i] = m_lvl[i];
            exp_tk[i] = m_tk[i];
        end
        check_eq("sq", 32'(sq), 32'(exp_sq));
        check_eq("tick", 32'(tick), 32'(exp_tk));
        check_eq("cfg_err", 32'(cfg_err), 32'(m_err));
    endtask

    task automatic run(input int n, input bit e);
        for (int i = 0; i < n; i++) cyc(0, e, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1; en = 0; sync = 0; cfg_we = 0; cfg_ch = 0; cfg_half = 0;

        // Reset state and default period.
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 0);
        check_eq("rst_sq", 32'(sq), 32'd0);
        check_eq("rst_tick", 32'(tick), 32'd0);
        check_eq("rst_err", 32'(cfg_err), 32'd0);
        run(int'(DEF) - 1, 1);
        check_eq("def_pre_rise", 32'(sq[1]), 32'd0);
        run(1, 1);
        check_eq("def_rise", 32'(sq[1]), 32'd1);
        check_eq("def_tick", 32'(tick[1]), 32'd1);
        run(1, 1);
        check_eq("def_tick_once", 32'(tick[1]), 32'd0);

        // half=3 then sync: high after 3 edges, low after 6.
        cyc(0, 1, 0, 1, 0, 3);
        cyc(0, 1, 1, 0, 0, 0);
        run(2, 1);
        check_eq("h3_pre", 32'(sq[0]), 32'd0);
        run(1, 1);
        check_eq("h3_rise", 32'(sq[0]), 32'd1);
        check_eq("h3_tick", 32'(tick[0]), 32'd1);
        run(3, 1);
        check_eq("h3_fall", 32'(sq[0]), 32'd0);
        run(12, 1);

        // half=4 running, shrink to 2 mid-half.
        cyc(0, 1, 1, 1, 0, 4);
        run(2, 1);
        cyc(0, 1, 0, 1, 0, 2);
        run(14, 1);

        // Rejected writes; channel 0 period unaffected.
        cyc(0, 1, 0, 1, 0, 0);
        check_eq("err_zero", 32'(cfg_err), 32'd1);
        cyc(0, 1, 0, 1, 3, 5);
        check_eq("err_ch", 32'(cfg_err), 32'd1);
        run(1, 1);
        check_eq("err_once", 32'(cfg_err), 32'd0);
        run(8, 1);

        // half=5 with en low for 7 cycles mid-count.
        cyc(0, 1, 1, 1, 0, 5);
        run(6, 1);
        run(7, 0);
        run(12, 1);

        // Reset with sq high and a write pending.
        cyc(0, 1, 1, 1, 1, 2);
        run(2, 1);
        cyc(0, 1, 0, 1, 1, 6);
        cyc(1, 1, 0, 0, 0, 0);
        check_eq("rst_mid_sq", 32'(sq), 32'd0);
        run(int'(DEF) + 4, 1);

        // Random traffic.
        for (int n = 0; n < 4000; n++) begin
            bit r, e, s, we;
            r  = ($urandom_range(0, 499) == 0);
            s  = ($urandom_range(0, 59) == 0);
            e  = ($urandom_range(0, 99) < 85);
            we = ($urandom_range(0, 7) == 0);
            cyc(r, e, s, we, $urandom_range(0, 3), $urandom_range(0, 6));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
